pc_gen: RTL and testbench

- Program-counter generator for the single-cycle RISC datapath; sits directly upstream of the ALU operand-A select.
- Holds the current PC and drives it as the 5-bit pc_const operand, so PC-relative and link operations can route through the ALU.
- Computes the next PC from sequential increment, PC-relative branch, absolute jump, stall and halt.
- Optionally captures a link (return) address on jump-and-link.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/pc_next_calc.sv | 47 ++++
 rtl/pc_gen.sv | 99 +++++++++
 tb/tb_pc_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-state encoding and PC geometry defaults used by
// the PC generator, instruction memory and operand-A select.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int CPU_PC_W     = 5;
    localparam int CPU_RESET_PC = 0;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for the RUN state (stall > jump > branch > increment),
// plus sequential-wrap detection and the jump-and-link return address.
module pc_next_calc #(
    parameter int PC_W  = 5,
    parameter int OFF_W = 5
) (
    input  logic [PC_W-1:0]  i_pc,
    input  logic             i_stall,
    input  logic             i_branch_en,
    input  logic [OFF_W-1:0] i_br_offset,
    input  logic             i_jump_en,
    input  logic [PC_W-1:0]  i_jump_addr,
    input  logic             i_link_en,
    output logic [PC_W-1:0]  o_pc_next,
    output logic             o_wrap_next,
    output logic [PC_W-1:0]  o_link_next,
    output logic             o_link_we
);

    logic [PC_W:0]   w_off_ext;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_br_target;

    // Offset is widened one bit past the PC so a negative offset borrows correctly; carry is dropped.
    assign w_off_ext   = {{(PC_W + 1 - OFF_W){i_br_offset[OFF_W-1]}}, i_br_offset};
    assign w_br_target = PC_W'({1'b0, i_pc} + w_off_ext);
    assign w_pc_inc    = i_pc + PC_W'(1);
    assign o_link_next = w_pc_inc;

    always_comb begin
        o_pc_next   = i_pc;
        o_wrap_next = 1'b0;
        o_link_we   = 1'b0;
        if (i_stall) begin
            o_pc_next = i_pc;
        end else if (i_jump_en) begin
            o_pc_next = i_jump_addr;
            o_link_we = i_link_en;
        end else if (i_branch_en) begin
            o_pc_next = w_br_target;
        end else begin
            o_pc_next   = w_pc_inc;
            o_wrap_next = (i_pc == '1);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALT fetch FSM holding the PC, link address
// and the registered sequential-wrap pulse.
module pc_gen
    import cpu_pkg::*;
#(
    parameter int PC_W     = CPU_PC_W,
    parameter int RESET_PC = CPU_RESET_PC,
    parameter int OFF_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_en,
    input  logic [OFF_W-1:0] br_offset,
    input  logic             jump_en,
    input  logic [PC_W-1:0]  jump_addr,
    input  logic             link_en,
    input  logic             halt,
    input  logic             resume,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  link_addr,
    output logic             pc_valid,
    output logic             wrap,
    output logic             halted
);

    state_t          r_state;
    state_t          w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_link;
    logic            r_wrap;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_link_next;
    logic            w_wrap_next;
    logic            w_link_we;
    logic            w_run_update;

    pc_next_calc #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_next (
        .i_pc        (r_pc),
        .i_stall     (stall),
        .i_branch_en (branch_en),
        .i_br_offset (br_offset),
        .i_jump_en   (jump_en),
        .i_jump_addr (jump_addr),
        .i_link_en   (link_en),
        .o_pc_next   (w_pc_next),
        .o_wrap_next (w_wrap_next),
        .o_link_next (w_link_next),
        .o_link_we   (w_link_we)
    );

    // Halt outranks every PC-changing control, so only a non-halting RUN cycle touches the PC.
    assign w_run_update = (r_state == ST_RUN) && !halt;

    always_comb begin
        w_state_next = r_state;
        pc_valid     = 1'b0;
        halted       = 1'b0;
        case (r_state)
            ST_BOOT: w_state_next = halt ? ST_HALT : ST_RUN;
            ST_RUN: begin
                pc_valid     = 1'b1;
                w_state_next = halt ? ST_HALT : ST_RUN;
            end
            ST_HALT: begin
                halted       = 1'b1;
                w_state_next = (resume && !halt) ? ST_RUN : ST_HALT;
            end
            default: w_state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
            r_pc    <= PC_W'(RESET_PC);
            r_link  <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_wrap  <= 1'b0;
            if (w_run_update) begin
                r_pc   <= w_pc_next;
                r_wrap <= w_wrap_next;
                if (w_link_we) begin
                    r_link <= w_link_next;
                end
            end
        end
    end

    assign pc        = r_pc;
    assign link_addr = r_link;
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: linear stimulus, outputs sampled on the falling edge.
module tb_pc_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stall, branch_en, jump_en, link_en, halt, resume;
    logic [4:0] br_offset, jump_addr;
    logic [4:0] pc, link_addr;
    logic       pc_valid, wrap, halted;

    int tests_run = 0;
    int tests_failed = 0;

    pc_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .branch_en (branch_en),
        .br_offset (br_offset),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .link_en   (link_en),
        .halt      (halt),
        .resume    (resume),
        .pc        (pc),
        .link_addr (link_addr),
        .pc_valid  (pc_valid),
        .wrap      (wrap),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall = 0; branch_en = 0; jump_en = 0; link_en = 0;
        halt = 0; resume = 0; br_offset = 5'd0; jump_addr = 5'd0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pc", pc, 0);
        check("rst_link", link_addr, 0);
        check("rst_valid", pc_valid, 0);
        check("rst_wrap", wrap, 0);
        check("rst_halted", halted, 0);

        // Reset release: one BOOT cycle, then sequential fetch.
        rst_n = 1'b1;
        check("boot_pc", pc, 0);
        check("boot_valid", pc_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("seq_pc%0d", i), pc, i);
            check($sformatf("seq_valid%0d", i), pc_valid, 1);
        end

        // Sequential wrap 31 -> 0.
        repeat (28) step();
        check("pre_wrap_pc", pc, 31);
        check("pre_wrap_flag", wrap, 0);
        step();
        check("wrap_pc", pc, 0);
        check("wrap_flag", wrap, 1);
        step();
        check("post_wrap_pc", pc, 1);
        check("post_wrap_flag", wrap, 0);

        // Backward branch at pc=10 by -3.
        repeat (9) step();
        check("pre_br_pc", pc, 10);
        branch_en = 1; br_offset = 5'b11101;
        step();
        check("br_neg_pc", pc, 7);
        idle_inputs();

        // Jump without link to 30, then forward branch +4 wraps to 2 without a wrap pulse.
        jump_en = 1; jump_addr = 5'd30;
        step();
        check("jmp30_pc", pc, 30);
        check("jmp30_link", link_addr, 0);
        idle_inputs();
        branch_en = 1; br_offset = 5'd4;
        step();
        check("br_wrap_pc", pc, 2);
        check("br_wrap_flag", wrap, 0);
        idle_inputs();

        // Jump-and-link with a competing branch at pc=12.
        jump_en = 1; jump_addr = 5'd12;
        step();
        check("jmp12_pc", pc, 12);
        jump_en = 1; link_en = 1; branch_en = 1; br_offset = 5'd3; jump_addr = 5'd20;
        step();
        check("jal_pc", pc, 20);
        check("jal_link", link_addr, 13);
        idle_inputs();

        // link_en alone is ignored.
        link_en = 1;
        step();
        check("lonely_link_pc", pc, 21);
        check("lonely_link_addr", link_addr, 13);
        idle_inputs();

        // Stall at pc=5 holds even with a jump requested.
        jump_en = 1; jump_addr = 5'd5;
        step();
        check("jmp5_pc", pc, 5);
        stall = 1; jump_addr = 5'd9;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_pc%0d", i), pc, 5);
            check($sformatf("stall_wrap%0d", i), wrap, 0);
        end
        idle_inputs();
        step();
        check("unstall_pc", pc, 6);

        // Halt at pc=6; controls ignored while halted; halt+resume stays halted.
        halt = 1;
        step();
        check("halt_halted", halted, 1);
        check("halt_valid", pc_valid, 0);
        check("halt_pc", pc, 6);
        idle_inputs();
        jump_en = 1; jump_addr = 5'd25;
        step();
        check("halt_ign_pc", pc, 6);
        check("halt_ign_halted", halted, 1);
        idle_inputs();
        halt = 1; resume = 1;
        step();
        check("halt_res_both", halted, 1);
        idle_inputs();
        resume = 1;
        step();
        check("resume_halted", halted, 0);
        check("resume_valid", pc_valid, 1);
        check("resume_pc", pc, 6);
        idle_inputs();
        step();
        check("post_resume_pc", pc, 7);

        // Asynchronous reset mid-cycle during a jump-and-link at pc=17.
        jump_en = 1; jump_addr = 5'd17;
        step();
        check("jmp17_pc", pc, 17);
        jump_en = 1; link_en = 1; jump_addr = 5'd25;
        #2 rst_n = 1'b0;
        #1;
        check("async_pc", pc, 0);
        check("async_link", link_addr, 0);
        check("async_valid", pc_valid, 0);
        @(negedge clk);
        check("async_hold_pc", pc, 0);
        idle_inputs();

        // Halt during BOOT goes straight to HALTED.
        halt = 1;
        rst_n = 1'b1;
        step();
        check("boot_halt_halted", halted, 1);
        check("boot_halt_pc", pc, 0);
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
